scan_sequencer: RTL and testbench

Display scan controller: owns a tick prescaler of the same kind as the board's existing divided clocks, and uses its ticks to sequence time-multiplexed digit drive for a multi-digit seven-segment display. Each digit gets a blanking interval before its drive interval. A double-buffered value register is updated through a valid/ready handshake, and updates are applied only at frame boundaries so the display never tears. The block sits between the user-logic value source and the segment decoder/anode pins.

---
 rtl/scan_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 30 +++
 rtl/scan_sequencer.sv | 151 +++++++++++++++
 tb/tb_scan_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared encodings and defaults for the display scan logic and the other
// divided-clock blocks on the board.
package scan_pkg;

  // Scan FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_e;

  // Default prescaler geometry shared with the board's divided clocks
  localparam int DEF_DIV_W   = 11;
  localparam int DEF_DIV_MAX = 2047;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick divider: counts 0..DIV_MAX, one-cycle tick at the top.
// tick_pre flags the cycle before a tick (assuming no clear in between) so
// a consumer can register an output that lines up with the tick cycle.
module tick_prescaler import scan_pkg::*; #(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int DIV_MAX = DEF_DIV_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic tick_pre
);

  localparam logic [DIV_W-1:0] MAX_C   = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] MAXM1_C = DIV_W'(DIV_MAX - 1);

  logic [DIV_W-1:0] cnt_q;

  // Wrapping count with synchronous reset and clear
  always_ff @(posedge clk) begin
    if (!rst || clr)          cnt_q <= '0;
    else if (cnt_q == MAX_C)  cnt_q <= '0;
    else                      cnt_q <= cnt_q + 1'b1;
  end

  assign tick     = (cnt_q == MAX_C);
  assign tick_pre = (DIV_MAX == 0) ? 1'b1 : (cnt_q == MAXM1_C);

endmodule

// File: rtl/scan_sequencer.sv
// Multi-digit seven-segment scan controller: blank/drive sequencing per
// digit, double-buffered display value swapped only at frame boundaries.
module scan_sequencer import scan_pkg::*; #(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DIV_MAX     = DEF_DIV_MAX,
  parameter int DIGITS      = 4,
  parameter int DRIVE_TICKS = 3,
  parameter int BLANK_TICKS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic [DIGITS-1:0]     an,
  output logic [3:0]            nib,
  output logic                  frame_tick
);

  localparam int TMAX = (DRIVE_TICKS > BLANK_TICKS) ? DRIVE_TICKS : BLANK_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TW-1:0] BLANK_LAST_C = TW'(BLANK_TICKS - 1);
  localparam logic [TW-1:0] DRIVE_LAST_C = TW'(DRIVE_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST_C   = IW'(DIGITS - 1);

  scan_state_e          state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [4*DIGITS-1:0]  disp_q, disp_d;
  logic [4*DIGITS-1:0]  shadow_q, shadow_d;
  logic                 pend_q, pend_d;
  logic [DIGITS-1:0]    an_q, an_d;
  logic [3:0]           nib_q, nib_d;
  logic                 ft_q, ft_d;

  logic tick, tick_pre, pre_clr;
  logic accept, boundary;

  // Prescaler idles at zero and restarts from zero on every enable
  assign pre_clr = !en || (state_q == ST_IDLE);

  tick_prescaler #(
    .DIV_W   (DIV_W),
    .DIV_MAX (DIV_MAX)
  ) u_pre (
    .clk      (clk),
    .rst      (rst),
    .clr      (pre_clr),
    .tick     (tick),
    .tick_pre (tick_pre)
  );

  assign load_ready = ~pend_q;
  assign accept     = load_valid && !pend_q;
  // Last DRIVE tick of the last digit, taken this edge
  assign boundary   = en && tick && (state_q == ST_DRIVE) &&
                      (idx_q == IDX_LAST_C) && (tcnt_q == DRIVE_LAST_C);

  // State, counters, buffers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      tcnt_q   <= '0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      an_q     <= '1;
      nib_q    <= '0;
      ft_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tcnt_q   <= tcnt_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      an_q     <= an_d;
      nib_q    <= nib_d;
      ft_q     <= ft_d;
    end
  end

  // Scan FSM: tick-counted blank then drive per digit; en low aborts to IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_BLANK;
        idx_d   = '0;
        tcnt_d  = '0;
      end
      ST_BLANK: if (tick) begin
        if (tcnt_q == BLANK_LAST_C) begin
          state_d = ST_DRIVE;
          tcnt_d  = '0;
        end else begin
          tcnt_d  = tcnt_q + 1'b1;
        end
      end
      ST_DRIVE: if (tick) begin
        if (tcnt_q == DRIVE_LAST_C) begin
          state_d = ST_BLANK;
          tcnt_d  = '0;
          idx_d   = (idx_q == IDX_LAST_C) ? '0 : idx_q + 1'b1;
        end else begin
          tcnt_d  = tcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      tcnt_d  = '0;
    end
  end

  // Double buffer and output decode; frame_tick is raised one edge early so
  // it sits on the cycle whose closing edge is the frame boundary
  always_comb begin
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (boundary && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end else if (accept) begin
      shadow_d = load_data;
      pend_d   = 1'b1;
    end
    an_d  = '1;
    nib_d = '0;
    if (state_d == ST_DRIVE) begin
      an_d  = ~(DIGITS'(1) << idx_d);
      nib_d = disp_d[4*idx_d +: 4];
    end
    ft_d = (state_d == ST_DRIVE) && (idx_d == IDX_LAST_C) &&
           (tcnt_d == DRIVE_LAST_C) && tick_pre;
  end

  assign an         = an_q;
  assign nib        = nib_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench: the driver advances a timeline model (cycles since enable,
// modular slot/frame arithmetic) and queues the expected outputs per edge; a
// monitor pops and compares after every rising edge.
module tb_scan_sequencer;

  localparam int DIV_W = 2, DIV_MAX = 3, DIGITS = 4, DRIVE_TICKS = 2, BLANK_TICKS = 1;
  localparam int TICKC  = DIV_MAX + 1;
  localparam int SLOT   = (BLANK_TICKS + DRIVE_TICKS) * TICKC;
  localparam int FRAME  = DIGITS * SLOT;
  localparam int BLANKC = BLANK_TICKS * TICKC;

  typedef struct packed {
    logic [DIGITS-1:0] an;
    logic [3:0]        nib;
    logic              ft;
    logic              rdy;
  } exp_t;

  logic                 clk = 1'b1;
  logic                 rst, en, load_valid, load_ready, frame_tick;
  logic [4*DIGITS-1:0]  load_data;
  logic [DIGITS-1:0]    an;
  logic [3:0]           nib;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [4*DIGITS-1:0] m_disp = '0, m_shadow = '0;
  bit                  m_pend = 1'b0, m_run = 1'b0;
  int                  m_t = 0;

  always #5 clk = ~clk;

  scan_sequencer #(
    .DIV_W(DIV_W), .DIV_MAX(DIV_MAX), .DIGITS(DIGITS),
    .DRIVE_TICKS(DRIVE_TICKS), .BLANK_TICKS(BLANK_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data),
    .an(an), .nib(nib), .frame_tick(frame_tick)
  );

  function automatic exp_t model_out();
    exp_t x;
    int pos, dg, w;
    x.rdy = !m_pend;
    x.an  = '1;
    x.nib = '0;
    x.ft  = 1'b0;
    if (m_run) begin
      pos = m_t % FRAME;
      dg  = pos / SLOT;
      w   = pos % SLOT;
      if (w >= BLANKC) begin
        x.an  = ~(DIGITS'(1) << dg);
        x.nib = m_disp[4*dg +: 4];
      end
      x.ft = ((m_t + 1) % FRAME) == 0;
    end
    return x;
  endfunction

  // One clock: drive inputs for the next edge, advance model, queue expectation
  task automatic step(input logic r, input logic e, input logic v,
                      input logic [4*DIGITS-1:0] d);
    bit acc;
    @(negedge clk);
    rst = r; en = e; load_valid = v; load_data = d;
    acc = v && !m_pend;
    if (!r) begin
      m_disp = '0; m_shadow = '0; m_pend = 0; m_run = 0; m_t = 0;
    end else begin
      if (!e)          begin m_run = 0; m_t = 0; end
      else if (!m_run) begin m_run = 1; m_t = 0; end
      else             m_t++;
      if (m_run && m_t > 0 && (m_t % FRAME) == 0 && m_pend) begin
        m_disp = m_shadow;
        m_pend = 0;
      end else if (acc) begin
        m_shadow = d;
        m_pend   = 1;
      end
    end
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic run_until_pos(input int p);
    for (int i = 0; i < FRAME && (m_t % FRAME) != p; i++) step(1'b1, 1'b1, 1'b0, '0);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against queued expectations after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL scoreboard_empty at %0t: got none expected entry", $time);
      end else begin
        e = exp_q.pop_front();
        chk("an",         8'(an),         8'(e.an));
        chk("nib",        8'(nib),        8'(e.nib));
        chk("frame_tick", 8'(frame_tick), 8'(e.ft));
        chk("load_ready", 8'(load_ready), 8'(e.rdy));
      end
    end
  end

  initial begin
    // Reset, then idle, then scan with no loads (timing from enable)
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, '0);
    run(60);

    // Mid-frame load, then a second offer while pending (must be ignored)
    run_until_pos(20);
    step(1'b1, 1'b1, 1'b1, 16'h4321);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 16'h8765);
    run(2 * FRAME);

    // Load sampled on the boundary edge itself
    for (int i = 0; i < FRAME && ((m_t + 1) % FRAME) != 0; i++) step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 16'hABCD);
    run(2 * FRAME + 5);

    // Disable during digit 2 drive, then restart
    run_until_pos(2 * SLOT + BLANKC + 2);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, '0);
    run(FRAME + 5);

    // Reset with a pending load, then run a frame showing zeros
    run_until_pos(10);
    step(1'b1, 1'b1, 1'b1, 16'h9999);
    run(5);
    step(1'b0, 1'b1, 1'b0, '0);
    run(FRAME + 5);

    // Randomized traffic with occasional disables and resets
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 499) != 0, $urandom_range(0, 199) != 0,
           $urandom_range(0, 7) == 0, 16'($urandom));

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
